// File: rtl/uroba_pkg.sv
// Shared widths, stage record and rounding helper for the UROBA approximate multiplier.
package uroba_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned SH_W   = 6;
  localparam int unsigned TAG_W  = 3;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  id;
    logic [PROD_W-1:0] payload;
  } uroba_stage_t;

  typedef struct packed {
    logic            zero;
    logic [SH_W-1:0] sh;
  } uroba_round_t;

  // log2 of r(v): 1->0, 2/3->1, otherwise k or k+1 depending on the bit below the leading one.
  function automatic uroba_round_t uroba_round_shift(input logic [OP_W-1:0] v);
    uroba_round_t r;
    int unsigned  k;
    k      = 0;
    r.zero = (v == '0);
    for (int unsigned i = 0; i < OP_W; i++) begin
      if (v[i]) k = i;
    end
    if (k >= 2) r.sh = v[k-1] ? SH_W'(k + 1) : SH_W'(k);
    else        r.sh = SH_W'(k);
    return r;
  endfunction

endpackage

// File: rtl/uroba_pipe.sv
// Three-stage UROBA datapath; all stages advance together on adv and hold otherwise.
module uroba_pipe
  import uroba_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_id,
  input  logic [OP_W-1:0]   in_x,
  input  logic [OP_W-1:0]   in_y,
  output logic              out_valid,
  output logic [TAG_W-1:0]  out_id,
  output logic [PROD_W-1:0] out_p
);

  uroba_stage_t      s1_q, s1_d;
  uroba_stage_t      s2_q, s2_d;
  uroba_stage_t      s3_q, s3_d;
  logic [PROD_W-1:0] s2_b_q, s2_b_d;
  logic [PROD_W-1:0] s2_c_q, s2_c_d;

  uroba_round_t      rnd_x, rnd_y;
  logic [SH_W:0]     sh_sum;
  logic              kill;
  logic [PROD_W-1:0] term_a, term_b, term_c;

  // Terms are kept at 64 bits: the result is taken modulo 2^64, so bits above 63 never matter.
  always_comb begin
    rnd_x  = uroba_round_shift(s1_q.payload[PROD_W-1:OP_W]);
    rnd_y  = uroba_round_shift(s1_q.payload[OP_W-1:0]);
    sh_sum = {1'b0, rnd_x.sh} + {1'b0, rnd_y.sh};
    kill   = rnd_x.zero | rnd_y.zero;
    term_a = {{OP_W{1'b0}}, s1_q.payload[PROD_W-1:OP_W]} << rnd_y.sh;
    term_b = {{OP_W{1'b0}}, s1_q.payload[OP_W-1:0]} << rnd_x.sh;
    term_c = PROD_W'(1) << sh_sum;

    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    s2_b_d = s2_b_q;
    s2_c_d = s2_c_q;
    if (adv) begin
      s1_d.valid   = in_valid;
      s1_d.id      = in_id;
      s1_d.payload = {in_x, in_y};

      s2_d.valid   = s1_q.valid;
      s2_d.id      = s1_q.id;
      s2_d.payload = kill ? '0 : term_a;
      s2_b_d       = kill ? '0 : term_b;
      s2_c_d       = kill ? '0 : term_c;

      s3_d.valid   = s2_q.valid;
      s3_d.id      = s2_q.id;
      s3_d.payload = s2_q.payload + s2_b_q - s2_c_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      s2_b_q <= '0;
      s2_c_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      s2_b_q <= s2_b_d;
      s2_c_q <= s2_c_d;
    end
  end

  assign out_valid = s3_q.valid;
  assign out_id    = s3_q.id;
  assign out_p     = s3_q.payload;

endmodule

// File: rtl/uroba_mul_arbiter.sv
// Round-robin front end sharing one UROBA pipeline among NUM_REQ requesters.
// Optional accepted-op counter enabled by defining UROBA_PERF_CNT_EN.
module uroba_mul_arbiter
  import uroba_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_x,
  input  logic [OP_W*NUM_REQ-1:0] req_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_W-1:0]         out_id,
  output logic [PROD_W-1:0]       out_p
`ifdef UROBA_PERF_CNT_EN
  ,output logic [31:0]            op_count
`endif
);

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic              adv;
  logic              accept;
  int unsigned       idx;
  logic [OP_W-1:0]   sel_x, sel_y;
  logic              pipe_valid;
  logic [TAG_W-1:0]  pipe_id;
  logic [PROD_W-1:0] pipe_p;
  logic              unused_pipe_id;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(rr_ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end

    adv    = ~pipe_valid | out_ready;
    accept = grant_any & adv;

    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;

    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    sel_x = req_x[32'(grant_id)*OP_W +: OP_W];
    sel_y = req_y[32'(grant_id)*OP_W +: OP_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  uroba_pipe u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (adv),
    .in_valid  (accept),
    .in_id     (TAG_W'(grant_id)),
    .in_x      (sel_x),
    .in_y      (sel_y),
    .out_valid (pipe_valid),
    .out_id    (pipe_id),
    .out_p     (pipe_p)
  );

  assign out_valid      = pipe_valid;
  assign out_id         = pipe_id[ID_W-1:0];
  assign out_p          = pipe_p;
  assign unused_pipe_id = ^pipe_id;

`ifdef UROBA_PERF_CNT_EN
  logic [31:0] op_count_q, op_count_d;

  always_comb op_count_d = accept ? op_count_q + 32'd1 : op_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_uroba_mul_arbiter.sv
// Directed self-checking bench for uroba_mul_arbiter (NUM_REQ=4).
module tb_uroba_mul_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_x;
  logic [127:0] req_y;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_id;
  logic [63:0]  out_p;
`ifdef UROBA_PERF_CNT_EN
  logic [31:0]  op_count;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[10];

  uroba_mul_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_p     (out_p)
`ifdef UROBA_PERF_CNT_EN
    ,.op_count (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [31:0] x, input logic [31:0] y);
    req_x[i*32 +: 32] = x;
    req_y[i*32 +: 32] = y;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{32'd6,          32'd5,          64'd32};
    vecs[1] = '{32'd3,          32'd3,          64'd8};
    vecs[2] = '{32'd0,          32'hFFFF_FFFF,  64'd0};
    vecs[3] = '{32'd1,          32'd1,          64'd1};
    vecs[4] = '{32'd2,          32'd7,          64'd14};
    vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0000};
    vecs[6] = '{32'h8000_0000,  32'd1,          64'h8000_0000};
    vecs[7] = '{32'd12,         32'd10,         64'd128};
    vecs[8] = '{32'd5,          32'd0,          64'd0};
    vecs[9] = '{32'd100,        32'd3,          64'd328};

    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    out_ready = 1'b1;
    cyc();
    cyc();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_id",    64'(out_id),    64'd0);
    chk("rst_out_p",     out_p,          64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;

    // Single requests: grant, 3-cycle latency, tag and product.
    for (int i = 0; i < 10; i++) begin
      int r;
      r = i % 4;
      cyc();
      req_x = '0;
      req_y = '0;
      set_lane(r, vecs[i].x, vecs[i].y);
      req_valid = 4'b0001 << r;
      #1;
      chk("vec_ready", 64'(req_ready), 64'(4'b0001 << r));
      cyc();
      req_valid = '0;
      #1;
      chk("vec_lat1_valid", 64'(out_valid), 64'd0);
      cyc();
      #1;
      chk("vec_lat2_valid", 64'(out_valid), 64'd0);
      cyc();
      #1;
      chk("vec_valid", 64'(out_valid), 64'd1);
      chk("vec_id",    64'(out_id),    64'(r));
      chk("vec_p",     out_p,          vecs[i].p);
    end

    // Fairness: all four requesting, lane i computes (i+1)*1 = i+1.
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_lane(i, 32'(i + 1), 32'd1);
    for (int c = 0; c < 12; c++) begin
      cyc();
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) chk("fair_ready", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      if (c >= 3 && c < 11) begin
        chk("fair_valid", 64'(out_valid), 64'd1);
        chk("fair_id",    64'(out_id),    64'((c - 3) % 4));
        chk("fair_p",     out_p,          64'((c - 3) % 4 + 1));
      end
      if (c == 11) chk("fair_drain", 64'(out_valid), 64'd0);
    end

    // Backpressure: three in flight, consumer stalls for five cycles.
    for (int b = 0; b < 12; b++) begin
      cyc();
      req_valid = (b < 8) ? 4'b1111 : 4'b0000;
      out_ready = (b >= 3 && b < 8) ? 1'b0 : 1'b1;
      #1;
      if (b < 3) chk("bp_ready", 64'(req_ready), 64'(4'b0001 << b));
      if (b >= 3 && b < 8) begin
        chk("bp_stall_ready", 64'(req_ready), 64'd0);
        chk("bp_stall_valid", 64'(out_valid), 64'd1);
        chk("bp_stall_id",    64'(out_id),    64'd0);
        chk("bp_stall_p",     out_p,          64'd1);
      end
      if (b >= 8 && b < 11) begin
        chk("bp_rel_valid", 64'(out_valid), 64'd1);
        chk("bp_rel_id",    64'(out_id),    64'(b - 8));
        chk("bp_rel_p",     out_p,          64'(b - 7));
      end
      if (b == 11) chk("bp_drain", 64'(out_valid), 64'd0);
    end

    // Reset mid-stream: pointer is at 3, three ops launched, then a 1-cycle reset.
    for (int m = 0; m < 9; m++) begin
      cyc();
      req_valid = (m < 3 || m == 4) ? 4'b1111 : 4'b0000;
      rst_n     = (m == 3) ? 1'b0 : 1'b1;
      #1;
      if (m < 3) chk("mr_ready", 64'(req_ready), 64'(4'b0001 << ((m + 3) % 4)));
      if (m == 4) begin
        chk("mr_rst_valid", 64'(out_valid), 64'd0);
        chk("mr_rst_id",    64'(out_id),    64'd0);
        chk("mr_rst_p",     out_p,          64'd0);
        chk("mr_rst_ready", 64'(req_ready), 64'd1);
      end
      if (m == 5 || m == 6) chk("mr_no_stale", 64'(out_valid), 64'd0);
      if (m == 7) begin
        chk("mr_new_valid", 64'(out_valid), 64'd1);
        chk("mr_new_id",    64'(out_id),    64'd0);
        chk("mr_new_p",     out_p,          64'd1);
      end
      if (m == 8) chk("mr_drain", 64'(out_valid), 64'd0);
    end

`ifdef UROBA_PERF_CNT_EN
    // One accept since the last reset; add nine more.
    for (int n = 0; n < 10; n++) begin
      cyc();
      req_valid = (n < 9) ? 4'b1111 : 4'b0000;
      #1;
    end
    chk("op_count", 64'(op_count), 64'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
